// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand forwarding, load-use and PC-write stalls, memory-wait FSM.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
    parameter int NREGS    = 16,
    parameter int MEM_WAIT = 2,
    parameter int PERF_W   = 32,
    localparam int REG_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  RA1D,
    input  logic [REG_W-1:0]  RA2D,
    input  logic [REG_W-1:0]  RA1E,
    input  logic [REG_W-1:0]  RA2E,
    input  logic [REG_W-1:0]  WA3E,
    input  logic [REG_W-1:0]  WA3M,
    input  logic [REG_W-1:0]  WA3W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemToRegE,
    input  logic              MemToRegM,
    input  logic              PCSrcD,
    input  logic              PCSrcE,
    input  logic              PCSrcM,
    input  logic              PCSrcW,
    input  logic              BranchTakenE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [PERF_W-1:0] StallCycles,
    output logic [PERF_W-1:0] FlushCycles
);

    localparam logic [REG_W-1:0] PC_IDX = REG_W'(NREGS - 1);
    localparam logic [3:0] WAIT_INIT = (MEM_WAIT >= 2) ? 4'(MEM_WAIT - 2) : 4'd0;
    localparam logic HAS_WAIT = (MEM_WAIT > 0);
    localparam logic ONE_WAIT = (MEM_WAIT == 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       mem_stall;
    logic       ldr_stall;
    logic       pc_wr_pending;

    function automatic logic reg_match(
        input logic [REG_W-1:0] a,
        input logic [REG_W-1:0] b
    );
        return (a == b) && (a != PC_IDX);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] ra);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWriteM && reg_match(WA3M, ra))
            sel = 2'b10;
        else if (RegWriteW && reg_match(WA3W, ra))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(RA1E);
        ForwardBE = fwd_sel(RA2E);
    end

    assign ldr_stall = MemToRegE & RegWriteE &
                       (reg_match(WA3E, RA1D) | reg_match(WA3E, RA2D));
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    // RELEASE lets the held load advance exactly once before re-arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemToRegM && HAS_WAIT) begin
                        if (ONE_WAIT) begin
                            state <= RELEASE;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= RELEASE;
                    else
                        cnt <= cnt - 4'd1;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_stall = 1'b0;
        unique case (state)
            IDLE:    mem_stall = MemToRegM & HAS_WAIT;
            WAIT:    mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    always_comb begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
        if (!mem_stall) begin
            StallD = ldr_stall;
            StallF = ldr_stall | pc_wr_pending;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushE = ldr_stall | pc_wr_pending | BranchTakenE;
            FlushD = pc_wr_pending | PCSrcW | BranchTakenE;
            FlushW = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && !(&stall_cnt))
                stall_cnt <= stall_cnt + PERF_W'(1);
            if ((FlushD | FlushE | FlushW) && !(&flush_cnt))
                flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

    assign StallCycles = stall_cnt;
    assign FlushCycles = flush_cnt;
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard, checked
// against a cycle-owed stall model built from the hazard rules.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

    logic [1:0]  fae, fbe, fae4, fbe4;
    logic        sf, sd, se, sm, fd, fe, fw;
    logic        sf4, sd4, se4, sm4, fd4, fe4, fw4;
    logic [31:0] sc, fc;
    logic [3:0]  sc4, fc4;

    int nchecks = 0;
    int nerr = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(fae), .ForwardBE(fbe),
        .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
        .FlushD(fd), .FlushE(fe), .FlushW(fw),
        .StallCycles(sc), .FlushCycles(fc)
    );

    hazard_scoreboard #(.MEM_WAIT(4), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(fae4), .ForwardBE(fbe4),
        .StallF(sf4), .StallD(sd4), .StallE(se4), .StallM(sm4),
        .FlushD(fd4), .FlushE(fe4), .FlushW(fw4),
        .StallCycles(sc4), .FlushCycles(fc4)
    );

    // Model state: stall cycles still owed (>0), idle (0), release (-1).
    int     left2 = 0;
    int     left4 = 0;
    longint sc_m = 0;
    longint fc_m = 0;
    int     sc4_m = 0;
    int     fc4_m = 0;
    logic [6:0] e2, e4;

    function automatic bit mstall(input int left, input int mw);
        return (left > 0) || (left == 0 && MemToRegM && mw > 0);
    endfunction

    function automatic int nxt(input int left, input int mw);
        if (left > 1) return left - 1;
        if (left == 1) return -1;
        if (left == -1) return 0;
        if (MemToRegM && mw > 0) return (mw == 1) ? -1 : mw - 1;
        return 0;
    endfunction

    function automatic logic [1:0] fwd(input logic [3:0] ra);
        if (RegWriteM && WA3M == ra && ra != 4'd15) return 2'b10;
        if (RegWriteW && WA3W == ra && ra != 4'd15) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [6:0] exp_ctl(input bit ms);
        bit ldr, pcw;
        ldr = MemToRegE && RegWriteE && WA3E != 4'd15 &&
              (WA3E == RA1D || WA3E == RA2D);
        pcw = PCSrcD || PCSrcE || PCSrcM;
        if (ms) return 7'b1111001;
        return {ldr | pcw, ldr, 1'b0, 1'b0,
                pcw | PCSrcW | BranchTakenE,
                ldr | pcw | BranchTakenE, 1'b0};
    endfunction

    always_comb begin
        e2 = exp_ctl(mstall(left2, 2));
        e4 = exp_ctl(mstall(left4, 4));
    end

    always @(posedge clk) begin
        if (rst) begin
            left2 <= 0;
            left4 <= 0;
            sc_m  <= 0;
            fc_m  <= 0;
            sc4_m <= 0;
            fc4_m <= 0;
        end else begin
            left2 <= nxt(left2, 2);
            left4 <= nxt(left4, 4);
`ifdef HAZARD_PERF_CNT_EN
            if (e2[6] && sc_m < 64'hFFFFFFFF) sc_m <= sc_m + 1;
            if (|e2[2:0] && fc_m < 64'hFFFFFFFF) fc_m <= fc_m + 1;
            if (e4[6] && sc4_m < 15) sc4_m <= sc4_m + 1;
            if (|e4[2:0] && fc4_m < 15) fc4_m <= fc4_m + 1;
`endif
        end
    end

    task automatic clear_inputs;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        nchecks++;
        if ({sf, sd, se, sm, fd, fe, fw} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_ctl got %b want 0000000", {sf, sd, se, sm, fd, fe, fw});
        end
        nchecks++;
        if (sc !== 32'd0 || fc !== 32'd0 || sc4 !== 4'd0 || fc4 !== 4'd0) begin
            nerr++;
            $display("FAIL reset_cnt got %0d %0d %0d %0d want 0", sc, fc, sc4, fc4);
        end
        nchecks++;
        if (fae !== 2'b00 || fbe !== 2'b00) begin
            nerr++;
            $display("FAIL reset_fwd got %b %b want 00 00", fae, fbe);
        end
    endtask

    task automatic test_forward;
        do_reset();
        RegWriteM = 1'b1; WA3M = 4'd3;
        RegWriteW = 1'b1; WA3W = 4'd3;
        RA1E = 4'd3; RA2E = 4'd3;
        #1;
        nchecks++;
        if (fae !== 2'b10 || fbe !== 2'b10) begin
            nerr++;
            $display("FAIL fwd_mem_prio got %b %b want 10 10", fae, fbe);
        end
        RegWriteM = 1'b0;
        #1;
        nchecks++;
        if (fae !== 2'b01 || fbe !== 2'b01) begin
            nerr++;
            $display("FAIL fwd_wb got %b %b want 01 01", fae, fbe);
        end
        RegWriteM = 1'b1;
        WA3M = 4'd15; WA3W = 4'd15;
        RA1E = 4'd15; RA2E = 4'd15;
        #1;
        nchecks++;
        if (fae !== 2'b00 || fbe !== 2'b00) begin
            nerr++;
            $display("FAIL fwd_pc got %b %b want 00 00", fae, fbe);
        end
    endtask

    task automatic test_load_use;
        do_reset();
        MemToRegE = 1'b1; RegWriteE = 1'b1;
        WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
        #1;
        nchecks++;
        if ({sf, sd, fe, fd} !== 4'b1110) begin
            nerr++;
            $display("FAIL load_use got sf/sd/fe/fd=%b want 1110", {sf, sd, fe, fd});
        end
        @(negedge clk);
        MemToRegE = 1'b0; RegWriteE = 1'b0;
        #1;
        nchecks++;
        if ({sf, sd, fe} !== 3'b000) begin
            nerr++;
            $display("FAIL load_use_clear got %b want 000", {sf, sd, fe});
        end
    endtask

    task automatic test_mem_wait;
        logic [3:0] ms;
        ms = 4'b1011;
        do_reset();
        MemToRegM = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            nchecks++;
            if ({sf, se, sm, fw} !== {4{ms[c]}}) begin
                nerr++;
                $display("FAIL mem_wait_c%0d got %b want %b", c, {sf, se, sm, fw}, {4{ms[c]}});
            end
        end
        MemToRegM = 1'b0;
    endtask

    task automatic test_simultaneous;
        do_reset();
        MemToRegM = 1'b1; PCSrcE = 1'b1; BranchTakenE = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            nchecks++;
            if ({fd, fe} !== 2'b00) begin
                nerr++;
                $display("FAIL simul_stall_c%0d got %b want 00", c, {fd, fe});
            end
        end
        @(negedge clk);
        MemToRegM = 1'b0;
        #1;
        nchecks++;
        if ({fd, fe} !== 2'b11) begin
            nerr++;
            $display("FAIL simul_release got %b want 11", {fd, fe});
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        MemToRegM = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        nchecks++;
        if (se4 !== 1'b1) begin
            nerr++;
            $display("FAIL mid_wait_pre got %b want 1", se4);
        end
        rst = 1'b1;
        MemToRegM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nchecks++;
        if ({sf4, sd4, se4, sm4, fw4} !== 5'b0) begin
            nerr++;
            $display("FAIL mid_wait_post got %b want 00000", {sf4, sd4, se4, sm4, fw4});
        end
        nchecks++;
        if (sc4 !== 4'd0 || fc4 !== 4'd0) begin
            nerr++;
            $display("FAIL mid_wait_cnt got %0d %0d want 0 0", sc4, fc4);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (se4 !== 1'b0) begin
            nerr++;
            $display("FAIL mid_wait_idle got %b want 0", se4);
        end
    endtask

    task automatic test_saturation;
        logic [3:0]  exp4;
        logic [31:0] exp32;
`ifdef HAZARD_PERF_CNT_EN
        exp4 = 4'd15;
        exp32 = 32'd20;
`else
        exp4 = 4'd0;
        exp32 = 32'd0;
`endif
        do_reset();
        PCSrcD = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        nchecks++;
        if (sc4 !== exp4 || fc4 !== exp4) begin
            nerr++;
            $display("FAIL sat_20 got %0d %0d want %0d", sc4, fc4, exp4);
        end
        nchecks++;
        if (sc !== exp32) begin
            nerr++;
            $display("FAIL cnt32_20 got %0d want %0d", sc, exp32);
        end
        @(negedge clk);
        #1;
        nchecks++;
        if (sc4 !== exp4) begin
            nerr++;
            $display("FAIL sat_hold got %0d want %0d", sc4, exp4);
        end
        PCSrcD = 1'b0;
    endtask

    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 4) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
            WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom); MemToRegE = 1'($urandom);
            MemToRegM = ($urandom_range(0, 3) == 0);
            PCSrcD = ($urandom_range(0, 5) == 0);
            PCSrcE = ($urandom_range(0, 5) == 0);
            PCSrcM = ($urandom_range(0, 5) == 0);
            PCSrcW = ($urandom_range(0, 5) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 79) == 0);
            #1;
            nchecks++;
            if ({sf, sd, se, sm, fd, fe, fw} !== e2) begin
                nerr++;
                $display("FAIL rnd_ctl i=%0d got %b want %b", i, {sf, sd, se, sm, fd, fe, fw}, e2);
            end
            nchecks++;
            if ({sf4, sd4, se4, sm4, fd4, fe4, fw4} !== e4) begin
                nerr++;
                $display("FAIL rnd_ctl4 i=%0d got %b want %b", i, {sf4, sd4, se4, sm4, fd4, fe4, fw4}, e4);
            end
            nchecks++;
            if (fae !== fwd(RA1E) || fbe !== fwd(RA2E)) begin
                nerr++;
                $display("FAIL rnd_fwd i=%0d got %b %b want %b %b", i, fae, fbe, fwd(RA1E), fwd(RA2E));
            end
            nchecks++;
            if (sc !== sc_m[31:0] || fc !== fc_m[31:0] ||
                sc4 !== 4'(sc4_m) || fc4 !== 4'(fc4_m)) begin
                nerr++;
                $display("FAIL rnd_cnt i=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         i, sc, fc, sc4, fc4, sc_m, fc_m, sc4_m, fc4_m);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_simultaneous();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
